outport_arbiter: RTL

Parametrised output-port arbiter and crossbar-select controller for one router output port. It generalises the fixed five-port unicast/multicast arbitration to NPORT inputs and adds wormhole packet locking with tail-flit release, downstream back-pressure, a multicast priority class, a round-robin pointer and a lock-stall watchdog. There is one instance per output port. Its grant drives the input-buffer pop, and its registered select drives the pipelined crossbar data mux.

---
 rtl/outport_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/outport_arbiter.sv
// outport_arbiter: wormhole output-port arbiter and crossbar-select controller.
// Ports:
//   clk, rst_ (async active-high)     clock and reset
//   req[NPORT], req_port[NPORT*PORTW] per-input flit valid and requested output
//   mcast[NPORT], tail[NPORT]         head-flit multicast flag, packet-tail flag
//   out_ready                         downstream accepts a flit this cycle
//   grt[NPORT]                        combinational one-hot grant (flit transfers)
//   sel[NPORT], vld_out               registered grant / any-grant for the crossbar
//   busy, owner[IDW]                  port locked to a packet, and its input index
//   stall                             lock-stall watchdog flag (report only)
module outport_arbiter #(
    parameter int NPORT    = 5,
    parameter int PORTW    = 3,
    parameter int PORTID   = 0,
    parameter int MC_PRIO  = 1,
    parameter int STALLMAX = 15,
    parameter int IDW      = $clog2(NPORT)
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT*PORTW-1:0] req_port,
    input  logic [NPORT-1:0]       mcast,
    input  logic [NPORT-1:0]       tail,
    input  logic                   out_ready,
    output logic [NPORT-1:0]       grt,
    output logic [NPORT-1:0]       sel,
    output logic                   vld_out,
    output logic                   busy,
    output logic [IDW-1:0]         owner,
    output logic                   stall
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d, owner_q, owner_d, win, gidx;
    logic [NPORT-1:0] match, cand, sel_q;
    logic [7:0]       cnt_q, cnt_d;
    logic             vld_q, stall_q, stall_d, found, xfer;
    always_comb begin
        for (int i = 0; i < NPORT; i++)
            match[i] = req[i] && (req_port[i*PORTW +: PORTW] == PORTW'(PORTID));
        cand = (MC_PRIO != 0 && |(match & mcast)) ? (match & mcast) : match;
        // round-robin scan starting at ptr, wrapping past NPORT-1
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (!found && cand[(int'(ptr_q) + k) % NPORT]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr_q) + k) % NPORT);
            end
        end
        gidx = (state_q == LOCKED) ? owner_q : win;
        // grant is forced low while reset is asserted, independent of the clock
        xfer = !rst_ && out_ready && ((state_q == LOCKED) ? match[owner_q] : found);
        grt  = xfer ? (NPORT'(1) << gidx) : '0;
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (xfer) begin
            if (tail[gidx]) begin
                state_d = IDLE;
                ptr_d   = (gidx == IDW'(NPORT - 1)) ? '0 : gidx + IDW'(1);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = gidx;
            end
        end
        cnt_d   = (state_q == LOCKED && !xfer) ? ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1) : 8'd0;
        stall_d = cnt_d >= 8'(STALLMAX);
    end
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= 8'd0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            sel_q   <= grt;
            vld_q   <= |grt;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end
    assign sel     = sel_q;
    assign vld_out = vld_q;
    assign busy    = (state_q == LOCKED);
    assign owner   = owner_q;
    assign stall   = stall_q;
endmodule
